// File: rtl/trace_pkg.sv
// Shared constants, state encoding and sample-to-row mapping for the trace capture controller.
package trace_pkg;

  localparam int unsigned NUM_X = 640;
  localparam int unsigned NUM_Y = 480;
  localparam int unsigned DW    = 10;

  localparam logic [DW-1:0] NO_DOT = '1;
  localparam logic [DW-1:0] Y_MAX  = DW'(NUM_Y - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  // Larger samples plot higher on screen; anything at or above the top row pins to row 0.
  function automatic logic [DW-1:0] sample_to_row(input logic [DW-1:0] s);
    return (s >= Y_MAX) ? '0 : Y_MAX - s;
  endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Valid/ready sample stream feeding the trace capture controller.
interface trace_capture_ctrl_if;

  logic                     sample_valid;
  logic [trace_pkg::DW-1:0] sample_data;
  logic                     sample_ready;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);

endinterface

// File: rtl/trace_bank_ram.sv
// Two trace banks of NUM_X rows each; one write port, one registered read port (block-RAM template).
module trace_bank_ram
  import trace_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [DW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [DW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2][NUM_X];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Captures one screen-width of samples into a back bank and swaps it to display at a frame boundary.
// Optional rising-edge trigger on trig_level is built only when TRACE_TRIGGER_EN is defined.
module trace_capture_ctrl
  import trace_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 auto_rearm,
  input  logic [DW-1:0]        trig_level,
  trace_capture_ctrl_if.slave  smp,
  input  logic [DW-1:0]        pix_x,
  output logic [DW-1:0]        trace_y,
  output logic                 trace_valid,
  output logic                 busy,
  output logic                 capture_done
);

  state_t        state, state_nxt;
  logic [DW-1:0] wr_ptr, wr_ptr_nxt;
  logic          bank_sel;
  logic          xfer, trig, wr_en, swap;
  logic          rd_en, rd_ok;
  logic [DW-1:0] rd_data;

  assign smp.sample_ready = (state == ARMED) || (state == CAPTURE);
  assign xfer             = smp.sample_valid && smp.sample_ready;

`ifdef TRACE_TRIGGER_EN
  logic [DW-1:0] prev;
  logic          arm_entry;

  assign arm_entry = (state_nxt == ARMED) && (state != ARMED);
  assign trig      = (prev < trig_level) && (smp.sample_data >= trig_level);

  // All-ones on arming so the first sample after arming cannot look like a crossing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         prev <= NO_DOT;
    else if (arm_entry) prev <= NO_DOT;
    else if (xfer)      prev <= smp.sample_data;
  end
`else
  logic unused_trig_level;
  assign unused_trig_level = ^trig_level;
  assign trig              = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_en      = 1'b0;
    swap       = 1'b0;
    if (abort) begin
      state_nxt  = IDLE;
      wr_ptr_nxt = '0;
    end else begin
      case (state)
        IDLE: if (arm) state_nxt = ARMED;
        ARMED: begin
          if (xfer && trig) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = DW'(1);
            state_nxt  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (xfer) begin
            wr_en = 1'b1;
            if (wr_ptr == DW'(NUM_X - 1)) state_nxt  = DONE;
            else                          wr_ptr_nxt = wr_ptr + DW'(1);
          end
        end
        DONE: begin
          if (frame_start) begin
            swap       = 1'b1;
            wr_ptr_nxt = '0;
            state_nxt  = auto_rearm ? ARMED : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      bank_sel     <= 1'b0;
      trace_valid  <= 1'b0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      rd_ok        <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      bank_sel     <= bank_sel ^ swap;
      trace_valid  <= trace_valid | swap;
      busy         <= (state_nxt != IDLE);
      capture_done <= swap;
      rd_ok        <= trace_valid && rd_en;
    end
  end

  // Display bank is bank_sel; writes always target the other one.
  assign rd_en = (pix_x < DW'(NUM_X));

  trace_bank_ram u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (~bank_sel),
    .wr_addr (wr_ptr),
    .wr_data (sample_to_row(smp.sample_data)),
    .rd_en   (rd_en),
    .rd_bank (bank_sel),
    .rd_addr (pix_x),
    .rd_data (rd_data)
  );

  assign trace_y = rd_ok ? rd_data : NO_DOT;

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
- Sequences the dot-trace buffer that feeds the oscilloscope-style grid renderer.
- Accepts a valid/ready sample stream and captures one screen-width of samples into a back bank, optionally waiting for a trigger first.
- Swaps the back bank to display at the next frame boundary, so the renderer never shows a half-written trace.
- Serves the display bank to the renderer as trace_y, indexed by pix_x.

Parameters:
- NUM_X, 640, samples per trace (one per pixel column); depth of each bank.
- NUM_Y, 480, visible rows; sample values are clamped to NUM_Y-1.
- DW, 10, width of sample, coordinate and trace_y fields.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- arm  in  1  pulse: start a capture (honoured only in IDLE).
- abort  in  1  pulse: cancel the capture and return to IDLE without a swap.
- auto_rearm  in  1  level: after a swap, go straight to ARMED instead of IDLE.
- trig_level  in  DW  trigger threshold (used only with TRACE_TRIGGER_EN).
- sample_valid  in  1  sample handshake valid.
- sample_data  in  DW  raw sample value.
- sample_ready  out  1  sample handshake ready.
- pix_x  in  DW  renderer column address.
- trace_y  out  DW  screen row of the trace at pix_x; 1-cycle latency; all-ones means no dot.
- trace_valid  out  1  high once at least one bank swap has completed.
- busy  out  1  high in any state other than IDLE.
- capture_done  out  1  one-cycle pulse on the swap.

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, bank_sel=0, sample_ready=0, trace_valid=0, busy=0, capture_done=0, trace_y=all-ones. Bank RAM contents are not reset.
- Handshake: a sample transfers on a cycle with sample_valid && sample_ready. sample_ready is combinational from state: 1 in ARMED and CAPTURE, 0 in IDLE and DONE.
- States and transitions:
  - IDLE -> ARMED on arm.
  - ARMED: each transfer is examined for the trigger. A trigger transfer is written at wr_ptr=0 and the state moves to CAPTURE with wr_ptr=1. Non-trigger transfers are discarded.
  - CAPTURE: each transfer writes the back bank at wr_ptr, then wr_ptr increments. The transfer written at wr_ptr=NUM_X-1 moves the state to DONE.
  - DONE: on frame_start, toggle bank_sel, set trace_valid=1, pulse capture_done, reset wr_ptr=0. Next state is ARMED if auto_rearm=1, else IDLE.
- Stored value: y = NUM_Y-1-min(sample_data, NUM_Y-1), so larger samples plot higher. Sample 0 gives row 479; samples of 479 and above give row 0.
- Read path: trace_y is registered.
  - trace_valid=0 or pix_x>=NUM_X: trace_y=all-ones.
  - Otherwise: trace_y = display_bank[pix_x].
- Boundaries:
  - abort has priority over every other event in every state: wr_ptr=0, no swap, next state IDLE.
  - arm outside IDLE is ignored.
  - frame_start outside DONE is ignored.
  - The swap and the read in the same cycle are safe: the read register uses the old bank_sel and the new bank takes effect on the next cycle.
  - wr_ptr never exceeds NUM_X-1.
  - Reset mid-capture discards the capture. trace_valid returns to 0.

Optional Feature:
- TRACE_TRIGGER_EN defined:
  - The trigger is a rising crossing: previous accepted sample < trig_level and current sample >= trig_level.
  - The previous-sample register is cleared to all-ones on entry to ARMED, so the first sample after arming can never trigger.
- TRACE_TRIGGER_EN undefined:
  - The first transfer in ARMED is the trigger (free-running capture).
  - trig_level is unused and no comparator or previous-sample register is built.

Decomposition:
- Package trace_pkg: NUM_X/NUM_Y/DW defaults, the state enum (IDLE, ARMED, CAPTURE, DONE), and the NO_DOT all-ones constant.
- Sub-module trace_bank_ram: dual-bank simple dual-port RAM with a write port (bank, addr, data, we) and a registered read port (bank, addr). Must be inferable as block RAM.

Test Plan:
- Reset, then pix_x sweeps 0..639 -> trace_y=all-ones throughout; trace_valid=0; sample_ready=0.
- Trigger compiled out: arm, stream 640 samples with value 100 back-to-back, then frame_start -> capture_done pulses once; pix_x=0..639 reads trace_y=379; busy returns to 0.
- Clamp and out-of-range: stream samples 0, 479, 1000 -> trace_y 479, 0, 0 at pix_x 0, 1, 2; pix_x=700 -> all-ones.
- TRACE_TRIGGER_EN, trig_level=200, ramp 150..260 -> samples before 200 discarded; pix_x=0 reads y=279 (sample 200); DONE is reached only after 640 samples accepted.
- Abort at wr_ptr=300, then frame_start -> no swap; trace_y unchanged from the prior display bank; state IDLE.
- auto_rearm=1 with two consecutive captures -> bank_sel toggles twice; frame_start during CAPTURE is ignored; bubbles (sample_valid low) do not advance wr_ptr.
